// File: rtl/arm_cond_pkg.sv
// Shared encodings for the ARM condition field and the {N,Z,C,V} flag layout.
package arm_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/condcheck.sv
// Combinational evaluation of an instruction's Cond field against stored NZCV.
module condcheck
    import arm_cond_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_condex
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign w_n  = i_flags[FLAG_N];
    assign w_z  = i_flags[FLAG_Z];
    assign w_c  = i_flags[FLAG_C];
    assign w_v  = i_flags[FLAG_V];
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_condex = 1'b0;
        case (i_cond)
            COND_EQ: o_condex = w_z;
            COND_NE: o_condex = ~w_z;
            COND_CS: o_condex = w_c;
            COND_CC: o_condex = ~w_c;
            COND_MI: o_condex = w_n;
            COND_PL: o_condex = ~w_n;
            COND_VS: o_condex = w_v;
            COND_VC: o_condex = ~w_v;
            COND_HI: o_condex = w_c & ~w_z;
            COND_LS: o_condex = ~w_c | w_z;
            COND_GE: o_condex = w_ge;
            COND_LT: o_condex = ~w_ge;
            COND_GT: o_condex = ~w_z & w_ge;
            COND_LE: o_condex = w_z | ~w_ge;
            COND_AL: o_condex = 1'b1;
            // COND_NV is reserved and never executes
            default: o_condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/condlogic_mc.sv
// Conditional-execution unit of the multicycle core: holds NZCV and gates the
// decoder's write strobes by the condition evaluated in the previous cycle.
module condlogic_mc
    import arm_cond_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags
);

    logic [3:0] r_flags;
    logic       r_condexd;
    logic       w_condex;
    logic [1:0] w_flagwrite;
    logic       w_exec;

    condcheck u_condcheck (
        .i_cond  (Cond),
        .i_flags (r_flags),
        .o_condex(w_condex)
    );

    // Flags are written in the ALU state, so they use the undelayed condition.
    assign w_flagwrite = FlagW & {2{w_condex}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags   <= FLAG_RESET;
            r_condexd <= 1'b0;
        end else begin
            if (w_flagwrite[1]) r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (w_flagwrite[0]) r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
            r_condexd <= w_condex;
        end
    end

    // Writes requested while reset is held are dropped as well as the cycle after.
    assign w_exec   = r_condexd & ~reset;

    assign PCWrite  = (PCS & w_exec) | NextPC;
    assign RegWrite = RegW & w_exec;
    assign MemWrite = MemW & w_exec;
    assign Flags    = r_flags;

endmodule
